// File: rtl/hazard_pkg.sv
// Shared instruction-format, hazard-code and FSM definitions for the hazard scanner.
// The optional load-use code is enabled by defining HAZARD_LOADUSE_EN.
package hazard_pkg;

  // Instruction field positions: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2
  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 4;
  localparam int RS1_LSB = 2;
  localparam int RS2_LSB = 0;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    HZ_NONE    = 2'b00,
    HZ_RAW1    = 2'b01,
    HZ_RAW2    = 2'b10,
    HZ_LOADUSE = 2'b11
  } hcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    EV   = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef struct packed {
    opcode_e    op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  // One producer-history slot: does the instruction write a real register, and which one
  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [1:0] rd;
  } hist_t;

  localparam hist_t HIST_NONE = '0;

  function automatic instr_t decode(input logic [7:0] raw);
    instr_t i;
    i.op  = opcode_e'(raw[OP_LSB +: 2]);
    i.rd  = raw[RD_LSB +: 2];
    i.rs1 = raw[RS1_LSB +: 2];
    i.rs2 = raw[RS2_LSB +: 2];
    return i;
  endfunction

  // r0 is hardwired, so writing it never produces a dependency
  function automatic hist_t make_hist(input opcode_e op, input logic [1:0] rd);
    hist_t h;
    h.valid   = (op == OP_ALU || op == OP_LOAD) && (rd != 2'd0);
    h.is_load = (op == OP_LOAD);
    h.rd      = rd;
    return h;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Combinational classifier: compares one instruction's source registers against
// the two most recent producers. Load-use code only when HAZARD_LOADUSE_EN is defined.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [7:0] instr,
  input  hist_t      h1,
  input  hist_t      h2,
  output hcode_e     code
);

  instr_t ins;
  logic   use_rs1;
  logic   use_rs2;
  logic   use_rd;
  logic   hit1;
  logic   hit2;
  logic   unused_hist;

  assign ins = decode(instr);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    unique case (ins.op)
      OP_ALU: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_LOAD: use_rs1 = 1'b1;
      OP_STORE: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      default: ;
    endcase
  end

  assign hit1 = h1.valid && ((use_rs1 && ins.rs1 == h1.rd) ||
                             (use_rs2 && ins.rs2 == h1.rd) ||
                             (use_rd  && ins.rd  == h1.rd));
  assign hit2 = h2.valid && ((use_rs1 && ins.rs1 == h2.rd) ||
                             (use_rs2 && ins.rs2 == h2.rd) ||
                             (use_rd  && ins.rd  == h2.rd));

  // Distance-1 dependency dominates; distance 2 is reported only when distance 1 is clean
  always_comb begin
    code = HZ_NONE;
    if (hit1) begin
`ifdef HAZARD_LOADUSE_EN
      code = h1.is_load ? HZ_LOADUSE : HZ_RAW1;
`else
      code = HZ_RAW1;
`endif
    end else if (hit2) begin
      code = HZ_RAW2;
    end
  end

`ifdef HAZARD_LOADUSE_EN
  assign unused_hist = h2.is_load;
`else
  assign unused_hist = h1.is_load ^ h2.is_load;
`endif

endmodule

// File: rtl/hazard_scanner.sv
// Walks the instruction memory entry by entry, classifies each instruction's hazard
// and writes the code to the hazard memory. Load-use code gated by HAZARD_LOADUSE_EN.
module hazard_scanner
  import hazard_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          im_rd_en,
  output logic [AW-1:0] im_addr,
  input  logic [7:0]    im_rdata,
  output logic          hm_we,
  output logic [AW-1:0] hm_addr,
  output logic [1:0]    hm_wdata,
  output logic [AW:0]   hazard_cnt
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e        state;
  logic [AW-1:0] idx;
  hist_t         h1;
  hist_t         h2;
  hist_t         h_new;
  hcode_e        code;

  hazard_cmp u_cmp (
    .instr (im_rdata),
    .h1    (h1),
    .h2    (h2),
    .code  (code)
  );

  assign h_new = make_hist(opcode_e'(im_rdata[OP_LSB +: 2]), im_rdata[RD_LSB +: 2]);

  // Read data only arrives in EV, so the code is driven combinationally and gated by the strobe
  assign hm_wdata = hm_we ? code : HZ_NONE;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      h1         <= HIST_NONE;
      h2         <= HIST_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      im_rd_en   <= 1'b0;
      im_addr    <= '0;
      hm_we      <= 1'b0;
      hm_addr    <= '0;
      hazard_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RD;
            idx        <= '0;
            h1         <= HIST_NONE;
            h2         <= HIST_NONE;
            hazard_cnt <= '0;
            busy       <= 1'b1;
            im_rd_en   <= 1'b1;
            im_addr    <= '0;
          end
        end

        RD: begin
          state    <= EV;
          im_rd_en <= 1'b0;
          im_addr  <= '0;
          hm_we    <= 1'b1;
          hm_addr  <= idx;
        end

        EV: begin
          hm_we   <= 1'b0;
          hm_addr <= '0;
          h2      <= h1;
          h1      <= h_new;
          if (code != HZ_NONE) hazard_cnt <= hazard_cnt + (AW+1)'(1);
          if (idx == LAST_IDX) begin
            state <= DONE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= RD;
            idx      <= idx + AW'(1);
            im_rd_en <= 1'b1;
            im_addr  <= idx + AW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scanner.sv
// Scoreboard bench for hazard_scanner: directed programs push expected hazard writes
// and final counts; a negedge monitor pops and compares whatever the DUT presents.
module tb_hazard_scanner;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [7:0] NOP = 8'hC0;
`ifdef HAZARD_LOADUSE_EN
  localparam logic [1:0] LU = 2'b11;
`else
  localparam logic [1:0] LU = 2'b01;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    code;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          im_rd_en;
  logic [AW-1:0] im_addr;
  logic [7:0]    im_rdata = '0;
  logic          hm_we;
  logic [AW-1:0] hm_addr;
  logic [1:0]    hm_wdata;
  logic [AW:0]   hazard_cnt;

  logic [7:0] mem [DEPTH];
  logic [1:0] exp_codes [DEPTH];
  wr_t        exp_q [$];
  int         exp_cnt_q [$];
  wr_t        mon_e;
  int         mon_cnt;
  int         tests = 0;
  int         fails = 0;
  int         done_seen = 0;

  always #5 clk = ~clk;

  hazard_scanner #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .im_rd_en   (im_rd_en),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .hm_we      (hm_we),
    .hm_addr    (hm_addr),
    .hm_wdata   (hm_wdata),
    .hazard_cnt (hazard_cnt)
  );

  // Synchronous-read instruction memory
  always @(posedge clk) if (im_rd_en) im_rdata <= mem[im_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hm_we) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("hm_addr", 32'(hm_addr), 32'(mon_e.addr));
        check($sformatf("code[%0d]", mon_e.addr), 32'(hm_wdata), 32'(mon_e.code));
      end
    end else begin
      check("hm_idle_zero", 32'({hm_addr, hm_wdata}), 32'd0);
    end
    if (!im_rd_en) check("im_addr_idle_zero", 32'(im_addr), 32'd0);
    if (done) begin
      done_seen++;
      check("done_expected", 32'(exp_cnt_q.size() != 0), 32'd1);
      if (exp_cnt_q.size() != 0) begin
        mon_cnt = exp_cnt_q.pop_front();
        check("hazard_cnt", 32'(hazard_cnt), 32'(mon_cnt));
      end
    end
  end

  task automatic clear_vec();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]       = NOP;
      exp_codes[i] = 2'b00;
    end
  endtask

  task automatic push_expect(input int exp_cnt);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{addr: AW'(i), code: exp_codes[i]});
    exp_cnt_q.push_back(exp_cnt);
  endtask

  // inject: cycle index at which a stray start is pulsed mid-scan (0 = none)
  task automatic run_scan(input string tag, input int exp_cnt, input int inject, input bit inject_done);
    int edges;
    int d0;
    push_expect(exp_cnt);
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    check({tag, "_rd_first"}, 32'({busy, im_rd_en, im_addr}), 32'({1'b1, 1'b1, 4'd0}));
    while (!done && edges < 100) begin
      start = (edges == inject);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(edges), 32'(2 * DEPTH + 1));
    if (inject_done && done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 32'(done_seen - d0), 32'd1);
    check({tag, "_idle_after"}, 32'({busy, done, im_rd_en, hm_we}), 32'd0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int edges;
    clear_vec();
    #1;
    check("reset_outputs_initial",
          32'({busy, done, im_rd_en, hm_we, im_addr, hm_addr, hm_wdata, hazard_cnt}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Distance-1 RAW, with a stray start mid-scan
    clear_vec(); mem[0] = 8'h1B; mem[1] = 8'h24; exp_codes[1] = 2'b01;
    run_scan("raw1", 1, 5, 1'b0);

    // Distance-2 RAW across a NOP; start during DONE is ignored
    clear_vec(); mem[0] = 8'h1B; mem[1] = 8'hC0; mem[2] = 8'h24; exp_codes[2] = 2'b10;
    run_scan("raw2", 1, 0, 1'b1);

    // LOAD producer at distance 1
    clear_vec(); mem[0] = 8'h60; mem[1] = 8'h38; exp_codes[1] = LU;
    run_scan("loaduse", 1, 0, 1'b0);

    // r0 writers never produce hazards; LOAD at distance 2 gives plain RAW2
    clear_vec(); mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h60; mem[3] = 8'hC0; mem[4] = 8'h38;
    exp_codes[4] = 2'b10;
    run_scan("r0_load2", 1, 0, 1'b0);

    // STORE reads its rd field
    clear_vec(); mem[0] = 8'h1B; mem[1] = 8'h94; exp_codes[1] = 2'b01;
    run_scan("store_rd", 1, 0, 1'b0);

    // Distance 1 beats distance 2; hazard at the last entry
    clear_vec(); mem[0] = 8'h1B; mem[1] = 8'h24; mem[2] = 8'h39; mem[14] = 8'h1B; mem[15] = 8'h44;
    exp_codes[1] = 2'b01; exp_codes[2] = 2'b01; exp_codes[15] = 2'b01;
    run_scan("prio_last", 3, 0, 1'b0);

    // History from the previous scan (r1 producer at entry 14) must not leak into entry 0
    clear_vec(); mem[0] = 8'h24;
    run_scan("fresh_hist", 0, 0, 1'b0);

    // Reset asserted while entry 7 is being written
    clear_vec(); mem[0] = 8'h1B; mem[1] = 8'h24; exp_codes[1] = 2'b01;
    push_expect(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (!(hm_we && hm_addr == AW'(7)) && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("reached_entry7", 32'({hm_we, hm_addr}), 32'({1'b1, 4'd7}));
    check("cnt_before_reset", 32'(hazard_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs_midscan",
          32'({busy, done, im_rd_en, hm_we, im_addr, hm_addr, hm_wdata, hazard_cnt}), 32'd0);
    exp_q.delete();
    exp_cnt_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    clear_vec(); mem[0] = 8'h1B; mem[1] = 8'hC0; mem[2] = 8'h24; exp_codes[2] = 2'b10;
    run_scan("after_reset", 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
